// File: rtl/prio_enc_4x2_seq.sv
// Registered event-queuing priority encoder. Request pulses collect in a pending
// vector, and one encoded index is issued per handshake, highest priority first.
module prio_enc_4x2_seq #(
  parameter int N         = 4,
  parameter int IDXW      = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i,
  input  logic            clr,
  input  logic            ready,
  output logic [IDXW-1:0] y,
  output logic            valid,
  output logic [N-1:0]    pend,
  output logic            ovf
);

  logic            fire;
  logic            free;
  logic            any_pend;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] idx;
  logic [N-1:0]    take;

  assign fire     = valid & ready;
  assign free     = ~valid | fire;
  assign any_pend = |pend;

  // Scan in priority-ascending order so the last set bit seen is the winner.
  always_comb begin
    sel  = '0;
    idx  = '0;
    take = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (MSB_FIRST != 0) ? IDXW'(k) : IDXW'(N - 1 - k);
      if (pend[idx]) sel = idx;
    end
    if (free && any_pend) take[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      y     <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      pend  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      pend <= (pend & ~take) | i;
      ovf  <= |(i & pend & ~take);
      if (free) begin
        valid <= any_pend;
        if (any_pend) y <= sel;
      end
    end
  end

endmodule
